// File: rtl/w5300_conf_seq.sv
// W5300 bring-up sequencer: soft reset, MR poll, then network and buffer configuration over a req/rsp bus.
// Define W5300_CONF_READBACK_EN to verify every configuration write (steps 3-22) with a readback.
module w5300_conf_seq #(
  parameter logic [47:0] MAC_ADDR = 48'h0008dc010203,
  parameter logic [31:0] GW_ADDR  = 32'hc0a86f01,
  parameter logic [31:0] SUB_MASK = 32'hffffff00,
  parameter logic [31:0] IP_ADDR  = 32'hc0a86f0f,
  parameter logic [15:0] RTR_VAL  = 16'h0fa0,
  parameter int          SOCK_NUM = 1,
  parameter int          TX_KB    = 8,
  parameter int          RX_KB    = 8,
  parameter int          POLL_MAX = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  err_step,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_rd,
  output logic [9:0]  req_addr,
  output logic [15:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata
);

  generate
    if (SOCK_NUM < 1 || SOCK_NUM > 8) begin : g_bad_sock
      $error("w5300_conf_seq: SOCK_NUM must be 1..8");
    end
    if (SOCK_NUM * TX_KB > 64 || SOCK_NUM * RX_KB > 64) begin : g_bad_mem
      $error("w5300_conf_seq: socket buffers exceed 64 kB");
    end
  endgenerate

`ifdef W5300_CONF_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  localparam int PW = ($clog2(POLL_MAX + 1) > 10) ? $clog2(POLL_MAX + 1) : 10;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [4:0]    POLL_STEP = 5'd1;
  localparam logic [4:0]    LAST_STEP = 5'd22;
  localparam logic [15:0]   IMR_VAL   = 16'hd000 | 16'((1 << SOCK_NUM) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_CHECK, S_NEXT, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          rb_q, rb_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [5:0]    err_step_q, err_step_d;
  logic          rd_now;

  function automatic logic [7:0] sock_kb(input int idx, input int n_kb);
    return (idx < SOCK_NUM) ? 8'(n_kb) : 8'h00;
  endfunction

  function automatic logic [9:0] step_addr(input logic [4:0] s);
    logic [9:0] a;
    a = 10'h000;
    if (s == 5'd3)                     a = 10'h004;
    else if (s >= 5'd4 && s <= 5'd6)   a = 10'h008 + 10'(2 * (int'(s) - 4));
    else if (s >= 5'd7 && s <= 5'd13)  a = 10'h010 + 10'(2 * (int'(s) - 7));
    else if (s >= 5'd14 && s <= 5'd21) a = 10'h020 + 10'(2 * (int'(s) - 14));
    else if (s == 5'd22)               a = 10'h030;
    return a;
  endfunction

  // Multi-word values go out most significant half first (big-endian register layout).
  function automatic logic [15:0] step_data(input logic [4:0] s);
    int pt;
    int pr;
    logic [15:0] d;
    pt = 2 * (int'(s) - 14);
    pr = 2 * (int'(s) - 18);
    d  = 16'h0000;
    case (s)
      5'd0:  d = 16'h0080;
      5'd2:  d = 16'hb800;
      5'd3:  d = IMR_VAL;
      5'd4:  d = MAC_ADDR[47:32];
      5'd5:  d = MAC_ADDR[31:16];
      5'd6:  d = MAC_ADDR[15:0];
      5'd7:  d = GW_ADDR[31:16];
      5'd8:  d = GW_ADDR[15:0];
      5'd9:  d = SUB_MASK[31:16];
      5'd10: d = SUB_MASK[15:0];
      5'd11: d = IP_ADDR[31:16];
      5'd12: d = IP_ADDR[15:0];
      5'd13: d = RTR_VAL;
      5'd14, 5'd15, 5'd16, 5'd17: d = {sock_kb(pt, TX_KB), sock_kb(pt + 1, TX_KB)};
      5'd18, 5'd19, 5'd20, 5'd21: d = {sock_kb(pr, RX_KB), sock_kb(pr + 1, RX_KB)};
      5'd22: d = 16'h00ff;
      default: d = 16'h0000;
    endcase
    return d;
  endfunction

  assign rd_now = (step_q == POLL_STEP) || rb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 5'd0;
      poll_q     <= '0;
      rb_q       <= 1'b0;
      rdata_q    <= 16'h0000;
      err_step_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_q     <= poll_d;
      rb_q       <= rb_d;
      rdata_q    <= rdata_d;
      err_step_q <= err_step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_d     = poll_q;
    rb_d       = rb_q;
    rdata_d    = rdata_q;
    err_step_d = err_step_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_ISSUE;
          step_d     = 5'd0;
          poll_d     = '0;
          rb_d       = 1'b0;
          err_step_d = 6'd0;
        end
      end
      S_ISSUE: begin
        if (req_ready) state_d = rd_now ? S_WAIT_RD : S_NEXT;
      end
      S_WAIT_RD: begin
        if (rsp_valid) begin
          rdata_d = rsp_rdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (step_q == POLL_STEP) begin
          // MR[7] self-clears when the chip's soft reset has finished.
          if (!rdata_q[7]) begin
            state_d = S_NEXT;
          end else if (poll_q == POLL_LAST) begin
            state_d    = S_ERR;
            err_step_d = {1'b0, step_q};
          end else begin
            poll_d  = poll_q + PW'(1);
            state_d = S_ISSUE;
          end
        end else if (rdata_q != step_data(step_q)) begin
          state_d    = S_ERR;
          err_step_d = {1'b0, step_q};
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (RB_EN && step_q >= 5'd3 && !rb_q) begin
          rb_d    = 1'b1;
          state_d = S_ISSUE;
        end else begin
          rb_d = 1'b0;
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state_q == S_ISSUE);
    req_rd    = 1'b0;
    req_addr  = 10'h000;
    req_wdata = 16'h0000;
    if (state_q == S_ISSUE) begin
      req_rd    = rd_now;
      req_addr  = step_addr(step_q);
      req_wdata = rd_now ? 16'h0000 : step_data(step_q);
    end
    busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
    err_step = err_step_q;
  end

endmodule

// File: tb/tb_w5300_conf_seq.sv
// Bench for w5300_conf_seq: three parameterisations driven by a randomized bus responder and checked
// against a register-list model of the bring-up sequence.
`timescale 1ns/1ps
module tb_w5300_conf_seq;

  localparam int NI = 3;
`ifdef W5300_CONF_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [47:0] MAC = 48'h0008dc010203;
  localparam logic [31:0] GW  = 32'hc0a86f01;
  localparam logic [31:0] SUB = 32'hffffff00;
  localparam logic [31:0] IP  = 32'hc0a86f0f;
  localparam int CFG_SOCK [NI] = '{1, 3, 1};
  localparam int CFG_TX   [NI] = '{8, 4, 8};
  localparam int CFG_RX   [NI] = '{8, 8, 8};
  localparam int CFG_PM   [NI] = '{1000, 1000, 4};

  logic clk = 1'b0;
  logic rst;
  logic        start[NI], req_ready[NI], rsp_valid[NI];
  logic [15:0] rsp_rdata[NI];
  logic        busy[NI], done[NI], err[NI], req_valid[NI], req_rd[NI];
  logic [5:0]  err_step[NI];
  logic [9:0]  req_addr[NI];
  logic [15:0] req_wdata[NI];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rd;
    logic [9:0] addr;
    logic [15:0] dat;
  } tx_t;
  tx_t exp_q[$];
  logic [15:0] last_w[1024];
  int n_mr_rd;

  always #5 clk = ~clk;

  w5300_conf_seq u_def (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .err_step(err_step[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rd(req_rd[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0])
  );

  w5300_conf_seq #(.SOCK_NUM(3), .TX_KB(4)) u_s3 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .err_step(err_step[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rd(req_rd[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1])
  );

  w5300_conf_seq #(.POLL_MAX(4)) u_p4 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]), .err(err[2]),
    .err_step(err_step[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_rd(req_rd[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2])
  );

  // Expected bus traffic, built from the register list of the bring-up procedure.
  task automatic build_model(input int k, input int n_busy, input int bad_step,
                             output bit x_err, output int x_step);
    logic [9:0]  a[23];
    logic [15:0] d[23];
    int polls;
    int sz[8];
    tx_t t;
    exp_q.delete();
    x_err  = 1'b0;
    x_step = 0;
    for (int i = 0; i < 23; i++) begin
      a[i] = 10'h000;
      d[i] = 16'h0000;
    end
    d[0] = 16'h0080;
    d[2] = 16'hb800;
    a[3] = 10'h004; d[3] = 16'hd000 | 16'((1 << CFG_SOCK[k]) - 1);
    for (int i = 0; i < 3; i++) begin
      a[4 + i] = 10'h008 + 10'(2 * i);
      d[4 + i] = 16'(MAC >> (16 * (2 - i)));
    end
    for (int i = 0; i < 2; i++) begin
      a[7 + i]  = 10'h010 + 10'(2 * i); d[7 + i]  = 16'(GW  >> (16 * (1 - i)));
      a[9 + i]  = 10'h014 + 10'(2 * i); d[9 + i]  = 16'(SUB >> (16 * (1 - i)));
      a[11 + i] = 10'h018 + 10'(2 * i); d[11 + i] = 16'(IP  >> (16 * (1 - i)));
    end
    a[13] = 10'h01c; d[13] = 16'h0fa0;
    for (int s = 0; s < 8; s++) sz[s] = (s < CFG_SOCK[k]) ? CFG_TX[k] : 0;
    for (int p = 0; p < 4; p++) begin
      a[14 + p] = 10'h020 + 10'(2 * p);
      d[14 + p] = 16'(sz[2 * p] * 256 + sz[2 * p + 1]);
    end
    for (int s = 0; s < 8; s++) sz[s] = (s < CFG_SOCK[k]) ? CFG_RX[k] : 0;
    for (int p = 0; p < 4; p++) begin
      a[18 + p] = 10'h028 + 10'(2 * p);
      d[18 + p] = 16'(sz[2 * p] * 256 + sz[2 * p + 1]);
    end
    a[22] = 10'h030; d[22] = 16'h00ff;

    t.rd = 1'b0; t.addr = a[0]; t.dat = d[0]; exp_q.push_back(t);
    polls = (n_busy + 1 < CFG_PM[k]) ? n_busy + 1 : CFG_PM[k];
    for (int i = 0; i < polls; i++) begin
      t.rd = 1'b1; t.addr = 10'h000; t.dat = 16'h0000; exp_q.push_back(t);
    end
    if (n_busy >= CFG_PM[k]) begin
      x_err = 1'b1; x_step = 1;
      return;
    end
    for (int s = 2; s < 23; s++) begin
      t.rd = 1'b0; t.addr = a[s]; t.dat = d[s]; exp_q.push_back(t);
      if (RB && s >= 3) begin
        t.rd = 1'b1; exp_q.push_back(t);
        if (s == bad_step) begin
          x_err = 1'b1; x_step = s;
          return;
        end
      end
    end
  endtask

  // Pulses start, then plays the bus slave until done/err, a transaction count, or a cycle budget.
  task automatic run_seq(input int k, input int rdy_pct, input int n_busy, input int bad_addr,
                         input bit stall_first, input bit noise, input int stop_after,
                         input string name, output int n_acc);
    bit pend = 1'b0;
    int dly = 0;
    bit held = 1'b0;
    logic hr;
    logic [9:0] ha;
    logic [15:0] hd, resp_val;
    int stall_left;
    int cyc = 0;
    tx_t e;
    n_acc = 0;
    n_mr_rd = 0;
    resp_val = 16'h0000;
    stall_left = stall_first ? 5 : 0;
    for (int i = 0; i < 1024; i++) last_w[i] = 16'hdead;
    @(negedge clk);
    start[k] = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      start[k] = 1'b0;
      if (cyc == 1) begin
        n_checks++;
        if ({busy[k], done[k], err[k], req_valid[k]} !== 4'b1001) begin
          n_fail++;
          $display("FAIL %s start_resp: busy/done/err/valid=%b want 1001", name,
                   {busy[k], done[k], err[k], req_valid[k]});
        end
      end
      if (held) begin
        n_checks++;
        if (req_valid[k] !== 1'b1 || req_rd[k] !== hr || req_addr[k] !== ha || req_wdata[k] !== hd) begin
          n_fail++;
          $display("FAIL %s hold: v=%b rd=%b a=%h d=%h want v=1 rd=%b a=%h d=%h", name,
                   req_valid[k], req_rd[k], req_addr[k], req_wdata[k], hr, ha, hd);
        end
      end
      if (pend && req_valid[k]) begin
        n_checks++; n_fail++;
        $display("FAIL %s outstanding: req_valid=1 while read pending, want 0", name);
      end
      if (done[k] || err[k]) break;
      if (cyc > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: no done/err after %0d cycles", name, cyc);
        break;
      end
      if (stop_after >= 0 && n_acc == stop_after && req_valid[k]) break;
      if (noise && busy[k] && $urandom_range(0, 9) == 0) start[k] = 1'b1;
      rsp_valid[k] = 1'b0;
      rsp_rdata[k] = 16'($urandom);
      if (pend) begin
        if (dly == 0) begin
          rsp_valid[k] = 1'b1;
          rsp_rdata[k] = resp_val;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end else if (noise && $urandom_range(0, 3) == 0) begin
        rsp_valid[k] = 1'b1;
      end
      req_ready[k] = ($urandom_range(1, 100) <= rdy_pct);
      if (req_valid[k] && stall_left > 0) begin
        req_ready[k] = 1'b0;
        stall_left--;
      end
      held = 1'b0;
      if (req_valid[k] && req_ready[k]) begin
        n_checks++;
        n_acc++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_req: rd=%b a=%h d=%h, want no request", name,
                   req_rd[k], req_addr[k], req_wdata[k]);
        end else begin
          e = exp_q.pop_front();
          if (req_rd[k] !== e.rd || req_addr[k] !== e.addr || (!e.rd && req_wdata[k] !== e.dat)) begin
            n_fail++;
            $display("FAIL %s tx%0d: rd=%b a=%h d=%h want rd=%b a=%h d=%h", name, n_acc,
                     req_rd[k], req_addr[k], req_wdata[k], e.rd, e.addr, e.dat);
          end
        end
        if (req_rd[k]) begin
          pend = 1'b1;
          dly = $urandom_range(0, 3);
          if (req_addr[k] == 10'h000) begin
            resp_val = (n_mr_rd < n_busy) ? (16'($urandom) | 16'h0080) : (16'($urandom) & 16'hff7f);
            n_mr_rd++;
          end else begin
            resp_val = (int'(req_addr[k]) == bad_addr) ? 16'h0000 : last_w[req_addr[k]];
          end
        end else begin
          last_w[req_addr[k]] = req_wdata[k];
        end
      end else if (req_valid[k]) begin
        held = 1'b1;
        hr = req_rd[k]; ha = req_addr[k]; hd = req_wdata[k];
      end
    end
    req_ready[k] = 1'b0;
    rsp_valid[k] = 1'b0;
  endtask

  task automatic check_end(input int k, input string name, input bit x_err, input int x_step);
    n_checks++;
    if (done[k] !== !x_err || err[k] !== x_err || err_step[k] !== 6'(x_step) || busy[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: done=%b err=%b step=%0d busy=%b want done=%b err=%b step=%0d busy=0",
               name, done[k], err[k], err_step[k], busy[k], !x_err, x_err, x_step);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing: %0d transactions not seen, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0; req_ready[k] = 1'b0; rsp_valid[k] = 1'b0; rsp_rdata[k] = 16'h0000;
    end
    #12;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if ({req_valid[k], req_rd[k], req_addr[k], req_wdata[k], busy[k], done[k], err[k], err_step[k]} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset%0d: outputs=%h want 0", k,
                 {req_valid[k], req_rd[k], req_addr[k], req_wdata[k], busy[k], done[k], err[k], err_step[k]});
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    bit xe; int xs; int n;
    build_model(0, 0, -1, xe, xs);
    run_seq(0, 100, 0, -1, 1'b0, 1'b0, -1, "defaults", n);
    check_end(0, "defaults", xe, xs);
    n_checks++;
    if (n != (RB ? 43 : 23) || last_w[10'h004] !== 16'hd001) begin
      n_fail++;
      $display("FAIL defaults count/imr: n=%0d imr=%h want n=%0d imr=d001", n, last_w[10'h004], RB ? 43 : 23);
    end
  endtask

  task automatic test_sock3();
    bit xe; int xs; int n;
    build_model(1, 0, -1, xe, xs);
    run_seq(1, 60, 0, -1, 1'b0, 1'b1, -1, "sock3", n);
    check_end(1, "sock3", xe, xs);
    n_checks++;
    if (last_w[10'h004] !== 16'hd007 || last_w[10'h020] !== 16'h0404 ||
        last_w[10'h022] !== 16'h0400 || last_w[10'h024] !== 16'h0000) begin
      n_fail++;
      $display("FAIL sock3 regs: imr=%h tms01=%h tms23=%h tms45=%h want d007 0404 0400 0000",
               last_w[10'h004], last_w[10'h020], last_w[10'h022], last_w[10'h024]);
    end
  endtask

  task automatic test_poll();
    bit xe; int xs; int n;
    build_model(0, 3, -1, xe, xs);
    run_seq(0, 70, 3, -1, 1'b0, 1'b1, -1, "poll", n);
    check_end(0, "poll", xe, xs);
    n_checks++;
    if (n_mr_rd != 4) begin
      n_fail++;
      $display("FAIL poll reads: got %0d want 4", n_mr_rd);
    end
  endtask

  task automatic test_poll_max();
    bit xe; int xs; int n; int extra = 0;
    build_model(2, 1000, -1, xe, xs);
    run_seq(2, 80, 1000, -1, 1'b0, 1'b1, -1, "poll_max", n);
    check_end(2, "poll_max", xe, xs);
    req_ready[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid[2]) extra++;
    end
    req_ready[2] = 1'b0;
    n_checks++;
    if (n_mr_rd != 4 || extra != 0 || err[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL poll_max after: reads=%0d extra=%0d err=%b want 4 0 1", n_mr_rd, extra, err[2]);
    end
  endtask

  task automatic test_stall_reset();
    bit xe; int xs; int n; int stray = 0;
    build_model(0, 0, -1, xe, xs);
    run_seq(0, 100, 0, -1, 1'b1, 1'b0, RB ? 17 : 10, "stall", n);
    n_checks++;
    if (req_valid[0] !== 1'b1 || req_addr[0] !== 10'h016 || req_wdata[0] !== 16'hff00) begin
      n_fail++;
      $display("FAIL stall step10: v=%b a=%h d=%h want 1 016 ff00", req_valid[0], req_addr[0], req_wdata[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({req_valid[0], req_rd[0], req_addr[0], req_wdata[0], busy[0], done[0], err[0], err_step[0]} !== 35'd0) begin
      n_fail++;
      $display("FAIL async_rst: outputs=%h want 0",
               {req_valid[0], req_rd[0], req_addr[0], req_wdata[0], busy[0], done[0], err[0], err_step[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    req_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_valid[0] || busy[0]) stray++;
    end
    req_ready[0] = 1'b0;
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_idle: %0d active cycles without start, want 0", stray);
    end
  endtask

  task automatic test_back_to_back();
    bit xe; int xs; int n;
    for (int r = 0; r < 2; r++) begin
      build_model(0, r, -1, xe, xs);
      run_seq(0, 50, r, -1, 1'b0, 1'b1, -1, "b2b", n);
      check_end(0, "b2b", xe, xs);
    end
  endtask

`ifdef W5300_CONF_READBACK_EN
  task automatic test_readback();
    bit xe; int xs; int n;
    build_model(0, 0, 8, xe, xs);
    run_seq(0, 75, 0, 10'h012, 1'b0, 1'b0, -1, "readback", n);
    check_end(0, "readback", xe, xs);
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_sock3();
    test_poll();
    test_poll_max();
    test_stall_reset();
    test_back_to_back();
`ifdef W5300_CONF_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/w5300_conf_seq.md
W5300_CONF_SEQ -- requirements
Module: w5300_conf_seq

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h0008dc010203, source hardware address (SHAR).
REQ-002 SHALL have parameter GW_ADDR, default 32'hc0a86f01, gateway (GAR).
REQ-003 SHALL have parameter SUB_MASK, default 32'hffffff00, subnet mask (SUBR).
REQ-004 SHALL have parameter IP_ADDR, default 32'hc0a86f0f, source IP (SIPR).
REQ-005 SHALL have parameter RTR_VAL, default 16'h0fa0, retransmission timeout.
REQ-006 SHALL have parameter SOCK_NUM, default 1, range 1..8, enabled sockets.
REQ-007 SHALL have parameter TX_KB, default 8, and RX_KB, default 8, buffer kB per enabled socket; SOCK_NUM*TX_KB<=64 and SOCK_NUM*RX_KB<=64, checked at elaboration.
REQ-008 SHALL have parameter POLL_MAX, default 1000, maximum MR_RST poll reads.
REQ-009 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-010 SHALL have ports: start in 1 begin sequence pulse; busy out 1; done out 1; err out 1; err_step out 6 failing step index.
REQ-011 SHALL have ports: req_valid out 1; req_ready in 1; req_rd out 1 (1 read, 0 write); req_addr out 10; req_wdata out 16.
REQ-012 SHALL have ports: rsp_valid in 1; rsp_rdata in 16 read data.

Function
REQ-013 SHALL run steps in order: 0 write MR=16'h0080; 1 poll-read MR; 2 write MR=16'hb800; 3 IMR; 4-6 SHAR0/2/4; 7-8 GAR0/2; 9-10 SUBR0/2; 11-12 SIPR0/2; 13 RTR; 14-17 TMS01R..TMS67R (10'h020..10'h026); 18-21 RMS01R..RMS67R (10'h028..10'h02e); 22 MTYPER=16'h00ff.
REQ-014 SHALL drive IMR=16'hd000 | ((1<<SOCK_NUM)-1).
REQ-015 SHALL place address/value words big-endian, most significant 16 bits at the lowest address.
REQ-016 SHALL drive TMSxyR/RMSxyR = {size_x, size_y} bytes, with size = TX_KB/RX_KB for socket index < SOCK_NUM, else 8'h00.
REQ-017 SHALL use FSM states IDLE, ISSUE, WAIT_RD, CHECK, NEXT, DONE, ERR; ISSUE->NEXT on write acceptance; ISSUE->WAIT_RD on read acceptance; WAIT_RD->CHECK on rsp_valid; NEXT->DONE after step 22.
REQ-018 SHALL hold req_valid, req_rd, req_addr, req_wdata stable from assertion until the cycle with req_valid&&req_ready; acceptance SHALL be that cycle.
REQ-019 SHALL assert req_valid at most one transaction outstanding; a new request SHALL not issue until the prior read's rsp_valid.
REQ-020 SHALL, in step 1, re-issue the MR read while rsp_rdata[7]=1; it SHALL advance when bit 7=0; it SHALL enter ERR with err_step=1 after POLL_MAX reads all returning bit 7=1.
REQ-021 SHALL accept start only in IDLE, DONE or ERR; it SHALL clear done/err and begin at step 0 the next cycle; start while busy SHALL be ignored.
REQ-022 SHALL assert busy in all states except IDLE, DONE, ERR; done SHALL be level-high in DONE; err SHALL be level-high in ERR.
REQ-023 SHALL ignore rsp_valid outside WAIT_RD.
REQ-024 SHALL implement the step sequencing with a 5-bit step counter and a 10-bit-minimum poll counter.

Reset
REQ-025 SHALL, on rst high, enter IDLE immediately, independent of clk.
REQ-026 SHALL reset outputs to: req_valid=0, req_rd=0, req_addr=0, req_wdata=0, busy=0, done=0, err=0, err_step=0.
REQ-027 SHALL abort any in-flight transaction on rst mid-sequence and restart only on a later start.

Configuration
REQ-028 SHALL, with macro W5300_CONF_READBACK_EN defined, follow each write of steps 3-22 with a read of the same address; on mismatch in CHECK it SHALL enter ERR with err_step = step index.
REQ-029 SHALL, without W5300_CONF_READBACK_EN, perform no readback; step 1 polling SHALL remain present.

Verification
REQ-030 SHALL cover defaults, ready always 1, first MR read returns 16'h0000 -> 23 transactions in the REQ-013 order; done=1; IMR write 16'hd001.
REQ-031 SHALL cover SOCK_NUM=3, TX_KB=4 -> IMR 16'hd007; TMS01R 16'h0404; TMS23R 16'h0400; TMS45R 16'h0000.
REQ-032 SHALL cover MR read returning 16'h0080 three times, then 16'h0000 -> exactly four step-1 reads, then step 2.
REQ-033 SHALL cover POLL_MAX=4 with MR always 16'h0080 -> err=1, err_step=1 after 4 reads, no further requests.
REQ-034 SHALL cover req_ready held 0 for 5 cycles -> req_* stable; assert rst at step 10 -> all outputs zero asynchronously.
REQ-035 SHALL cover READBACK_EN with GAR2 readback returning 16'h0000 -> err=1, err_step=8.
